param_cpu_core: RTL and testbench
=================================

Name: param_cpu_core

Overview:
- Parametrised successor to the fixed 4-bit, 16-register microprocessor datapath.
- Multi-cycle core: accepts one instruction at a time over a valid/ready handshake, runs it through an explicit FETCH/DECODE/EXEC/WB state machine, and reports the result and sticky flags.
- Sits between the IO/instruction source (switch/button front end or a future instruction buffer) and the display logic.

Parameters:
- DATA_W, 8, register and ALU data width (>=4).
- NUM_REGS, 16, register file depth (power of two, >=2).
- RA_W, $clog2(NUM_REGS), register-address width (derived, not overridden).
- INSTR_W, 4+3*RA_W, instruction width (derived).

Ports:
- clk  in  1  single core clock.
- rst_n  in  1  synchronous, active-low reset.
- instr  in  INSTR_W  {opcode[3:0], ra, rb_or_imm, rw}.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  core can accept (IDLE only).
- result  out  DATA_W  last written-back value.
- result_valid  out  1  one-cycle pulse at WB.
- ovf_flag  out  1  sticky carry-out/overflow.
- udf_flag  out  1  sticky borrow/underflow.
- illegal_op  out  1  one-cycle pulse, unused opcode.
- dbg_addr  in  RA_W  debug register select.
- dbg_data  out  DATA_W  registered read of regs[dbg_addr], 1-cycle latency.

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-low. rst_n=0 at a clk edge sets all registers to 0, state to IDLE, result 0, and result_valid, ovf_flag, udf_flag, illegal_op, dbg_data to 0. Reset mid-instruction aborts with no write-back.
- States:
  - IDLE: instr_ready=1. On instr_valid&&instr_ready, latch instr and go to DECODE.
  - DECODE: read regs[ra] and regs[rb]; select imm = zero-extend(rb field) to DATA_W.
  - EXEC: compute the ALU result and the flag candidates into a pipeline register.
  - WB: write regs[rw] (unless NOP/illegal), update result, pulse result_valid, go to IDLE.
- Latency: handshake at edge N, result_valid high during cycle N+3, instr_ready high again at N+4. Throughput is one instruction per 4 cycles. instr_valid while busy is ignored (ready=0).
- Opcodes:
  - 0 NOP
  - 1 ADD a+b
  - 2 SUB a-b
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 ADDI a+imm
  - 7 SUBI a-imm
  - 8 SHL a<<imm[2:0]
  - 9 SHR logical
  - A MOV a
  - B LDI imm
  - C-F illegal
- Arithmetic:
  - Computed at DATA_W+1 bits; results wrap modulo 2^DATA_W.
  - ADD/ADDI carry-out sets ovf_flag. SUB/SUBI borrow (a<b) sets udf_flag.
  - Flags are sticky until reset.
- NOP: no write and no result_valid, but still takes 4 cycles.
- Illegal opcode: illegal_op pulses in the WB cycle; no write, result unchanged.
- rw==ra is legal; the read value is from before the write.
- dbg_data: registered and independent of state. The cycle after a WB to dbg_addr, it shows the new value.

Optional Feature:
- SATURATE_EN defined: ADD/ADDI overflow clamps to 2^DATA_W-1; SUB/SUBI underflow clamps to 0. Flags are set as normal.
- Without it: plain modulo wrap.

Decomposition:
- Package cpu_pkg holds:
  - the opcode localparams (OP_NOP..OP_LDI);
  - the state enum (ST_IDLE, ST_DECODE, ST_EXEC, ST_WB);
  - the field-slicing helper functions.
- One sub-module, cpu_alu (combinational, parametrised by DATA_W, honours SATURATE_EN). The register file and FSM stay in the top.

Test Plan (DATA_W=8, NUM_REGS=16):
- Reset with rst_n=0 for 2 cycles -> all outputs 0, instr_ready=1; dbg_data=0 for every address.
- LDI r1,#5 then LDI r2,#7 then ADD r1,r2->r3 -> result=0x0C, result_valid 3 cycles after each handshake, dbg r3=0x0C.
- Overflow: LDI r4,#15, SHL r4,#4->r4 (0xF0), ADD r4,r4->r5 -> result=0xE0 and ovf_flag=1 (wrap); 0xFF with SATURATE_EN.
- SUBI r0,#1->r6 with r0=0 -> 0xFF and udf_flag=1 (0x00 with SATURATE_EN); flag still 1 after a following ADD.
- Opcode 0xD offered, and instr_valid held high while busy -> illegal_op pulse with no register change; only one instruction is accepted per 4 cycles.
- rst_n low during EXEC of ADD ->rw -> no write-back, regs[rw]=0, state IDLE next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for param_cpu_core.
//   - opcode constants OP_NOP..OP_LDI (4-bit opcode field; 0xC-0xF unused)
//   - FSM state enum (IDLE -> DECODE -> EXEC -> WB)
//   - helpers that slice {opcode, ra, rb_or_imm, rw} out of an instruction
//     word of any register-address width, plus opcode classification.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_SUBI = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_MOV  = 4'hA;
  localparam logic [3:0] OP_LDI  = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_WB
  } state_t;

  // The instruction is zero-extended to 64 bits by the caller so one helper
  // serves every register-address width.
  function automatic logic [3:0] instr_opcode(input logic [63:0] word, input int ra_w);
    return 4'(word >> (3 * ra_w));
  endfunction

  // idx 0 = rw, 1 = rb/imm, 2 = ra
  function automatic logic [15:0] instr_field(input logic [63:0] word, input int ra_w,
                                              input int idx);
    return 16'((word >> (idx * ra_w)) & ((64'd1 << ra_w) - 64'd1));
  endfunction

  function automatic logic op_writes(input logic [3:0] op);
    return (op != OP_NOP) && (op <= OP_LDI);
  endfunction

  function automatic logic op_illegal(input logic [3:0] op);
    return op > OP_LDI;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational ALU for param_cpu_core.
//   op   : 4-bit opcode
//   a    : regs[ra]
//   b    : regs[rb]
//   imm  : zero-extended rb field (ADDI/SUBI operand, LDI value, shift amount)
//   y    : result
//   ovf  : carry-out of ADD/ADDI
//   udf  : borrow of SUB/SUBI (a < operand)
// Optional macro SATURATE_EN: overflow clamps to all-ones, underflow to zero;
// flags are reported either way.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] y,
  output logic              ovf,
  output logic              udf
);

  logic [DATA_W-1:0] operand;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;

  assign operand = ((op == OP_ADDI) || (op == OP_SUBI)) ? imm : b;
  assign sum     = {1'b0, a} + {1'b0, operand};
  // Top bit of the (DATA_W+1)-bit difference is the borrow.
  assign diff    = {1'b0, a} - {1'b0, operand};

  always_comb begin
    y   = '0;
    ovf = 1'b0;
    udf = 1'b0;
    case (op)
      OP_ADD, OP_ADDI: begin
        y   = sum[DATA_W-1:0];
        ovf = sum[DATA_W];
      end
      OP_SUB, OP_SUBI: begin
        y   = diff[DATA_W-1:0];
        udf = diff[DATA_W];
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SHL:  y = a << imm[2:0];
      OP_SHR:  y = a >> imm[2:0];
      OP_MOV:  y = a;
      OP_LDI:  y = imm;
      default: y = '0;
    endcase
`ifdef SATURATE_EN
    if (ovf) y = '1;
    if (udf) y = '0;
`endif
  end

endmodule

// File: rtl/param_cpu_core.sv
// param_cpu_core: multi-cycle register-file CPU core, one instruction per
// four cycles (IDLE -> DECODE -> EXEC -> WB).
//   clk, rst_n     : single clock, synchronous active-low reset
//   instr          : {opcode[3:0], ra, rb_or_imm, rw}
//   instr_valid/instr_ready : handshake, ready only in IDLE
//   result/result_valid     : written-back value, valid pulses in WB
//   ovf_flag/udf_flag       : sticky carry / borrow
//   illegal_op              : pulse in WB for opcodes 0xC-0xF
//   dbg_addr/dbg_data       : registered debug read of the register file
// Optional macro SATURATE_EN (passed through to cpu_alu) selects saturating
// ADD/SUB instead of modulo wrap.
module param_cpu_core
  import cpu_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int NUM_REGS = 16,
  localparam int RA_W     = $clog2(NUM_REGS),
  localparam int INSTR_W  = 4 + 3 * RA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [DATA_W-1:0]  result,
  output logic               result_valid,
  output logic               ovf_flag,
  output logic               udf_flag,
  output logic               illegal_op,
  input  logic [RA_W-1:0]    dbg_addr,
  output logic [DATA_W-1:0]  dbg_data
);

  state_t             state;
  logic [INSTR_W-1:0] instr_q;
  logic [3:0]         op;
  logic [RA_W-1:0]    ra;
  logic [RA_W-1:0]    rb;
  logic [RA_W-1:0]    rw;
  logic [DATA_W-1:0]  a_q;
  logic [DATA_W-1:0]  b_q;
  logic [DATA_W-1:0]  imm_q;
  logic [DATA_W-1:0]  alu_y;
  logic               alu_ovf;
  logic               alu_udf;
  logic [DATA_W-1:0]  alu_q;
  logic               wb_we;
  logic [DATA_W-1:0]  regs [NUM_REGS];

  // The latched instruction stays stable until the next handshake, so every
  // stage decodes its fields straight from instr_q.
  assign op = instr_opcode(64'(instr_q), RA_W);
  assign ra = RA_W'(instr_field(64'(instr_q), RA_W, 2));
  assign rb = RA_W'(instr_field(64'(instr_q), RA_W, 1));
  assign rw = RA_W'(instr_field(64'(instr_q), RA_W, 0));

  assign instr_ready = (state == ST_IDLE);
  assign wb_we       = (state == ST_WB) && op_writes(op);

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op  (op),
    .a   (a_q),
    .b   (b_q),
    .imm (imm_q),
    .y   (alu_y),
    .ovf (alu_ovf),
    .udf (alu_udf)
  );

  // result/result_valid/illegal_op/flags are loaded on the EXEC->WB edge so
  // they are visible during the WB cycle itself; the register file is written
  // from the pipeline register alu_q at the end of WB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      instr_q      <= '0;
      a_q          <= '0;
      b_q          <= '0;
      imm_q        <= '0;
      alu_q        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      illegal_op   <= 1'b0;
      ovf_flag     <= 1'b0;
      udf_flag     <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      illegal_op   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            state   <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          a_q   <= regs[ra];
          b_q   <= regs[rb];
          imm_q <= DATA_W'(rb);
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          alu_q <= alu_y;
          if (op_writes(op)) begin
            result       <= alu_y;
            result_valid <= 1'b1;
          end
          illegal_op <= op_illegal(op);
          ovf_flag   <= ovf_flag | alu_ovf;
          udf_flag   <= udf_flag | alu_udf;
          state      <= ST_WB;
        end
        ST_WB: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_we) begin
      regs[rw] <= alu_q;
    end
  end

  // Forward the value being written so the debug port shows it the cycle
  // right after WB instead of one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dbg_data <= '0;
    end else if (wb_we && (rw == dbg_addr)) begin
      dbg_data <= alu_q;
    end else begin
      dbg_data <= regs[dbg_addr];
    end
  end

endmodule

// File: tb/tb_param_cpu_core.sv
// Directed testbench for param_cpu_core (DATA_W=8, NUM_REGS=16).
// Instruction encoding: {op[3:0], ra[3:0], rb_or_imm[3:0], rw[3:0]}.
// Expected values follow the SATURATE_EN build when that macro is defined.
module tb_param_cpu_core;

  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 16;

`ifdef SATURATE_EN
  localparam logic [7:0] EXP_ADD_OVF  = 8'hFF;
  localparam logic [7:0] EXP_SUBI_UDF = 8'h00;
`else
  localparam logic [7:0] EXP_ADD_OVF  = 8'hE0;
  localparam logic [7:0] EXP_SUBI_UDF = 8'hFF;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  result;
  logic        result_valid;
  logic        ovf_flag;
  logic        udf_flag;
  logic        illegal_op;
  logic [3:0]  dbg_addr;
  logic [7:0]  dbg_data;

  int vectors;
  int miscompares;

  param_cpu_core #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .result       (result),
    .result_valid (result_valid),
    .ovf_flag     (ovf_flag),
    .udf_flag     (udf_flag),
    .illegal_op   (illegal_op),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offers one instruction from IDLE and watches the four cycles after the
  // handshake (sampled on negedges, k=1..4). With hold=1 instr_valid stays
  // high through the busy cycles and is dropped just before ready returns.
  task automatic issue(input string tag, input logic [15:0] ins, input bit hold,
                       input bit exp_wr, input bit exp_ill,
                       input logic [7:0] exp_res, input logic [7:0] exp_dbg);
    int rv_cnt, rv_at, ill_cnt, ill_at, busy_ready;
    logic [7:0] res_seen, dbg4;
    logic ready4;
    rv_cnt = 0; rv_at = 0; ill_cnt = 0; ill_at = 0; busy_ready = 0;
    res_seen = '0; dbg4 = '0; ready4 = 1'b0;
    @(negedge clk);
    chk({tag, "/ready_before"}, 32'(instr_ready), 32'd1);
    instr       = ins;
    instr_valid = 1'b1;
    dbg_addr    = ins[3:0];
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (!hold || k == 4) instr_valid = 1'b0;
      if (result_valid) begin
        rv_cnt++;
        rv_at    = k;
        res_seen = result;
      end
      if (illegal_op) begin
        ill_cnt++;
        ill_at = k;
      end
      if (k < 4 && instr_ready) busy_ready++;
      if (k == 4) begin
        ready4 = instr_ready;
        dbg4   = dbg_data;
      end
    end
    chk({tag, "/rv_count"}, 32'(rv_cnt), exp_wr ? 32'd1 : 32'd0);
    chk({tag, "/rv_latency"}, 32'(rv_at), exp_wr ? 32'd3 : 32'd0);
    chk({tag, "/result_at_rv"}, 32'(res_seen), exp_wr ? 32'(exp_res) : 32'd0);
    chk({tag, "/ill_count"}, 32'(ill_cnt), exp_ill ? 32'd1 : 32'd0);
    chk({tag, "/ill_latency"}, 32'(ill_at), exp_ill ? 32'd3 : 32'd0);
    chk({tag, "/ready_busy"}, 32'(busy_ready), 32'd0);
    chk({tag, "/ready_again"}, 32'(ready4), 32'd1);
    chk({tag, "/result_hold"}, 32'(result), 32'(exp_res));
    chk({tag, "/dbg_rw"}, 32'(dbg4), 32'(exp_dbg));
  endtask

  initial begin
    int extra_rv, extra_ill;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    instr       = '0;
    instr_valid = 1'b0;
    dbg_addr    = '0;

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    #1;
    chk("rst/result", 32'(result), 32'd0);
    chk("rst/result_valid", 32'(result_valid), 32'd0);
    chk("rst/ovf", 32'(ovf_flag), 32'd0);
    chk("rst/udf", 32'(udf_flag), 32'd0);
    chk("rst/illegal", 32'(illegal_op), 32'd0);
    chk("rst/ready", 32'(instr_ready), 32'd1);
    chk("rst/dbg", 32'(dbg_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < NUM_REGS; a++) begin
      @(negedge clk);
      dbg_addr = 4'(a);
      @(negedge clk);
      chk($sformatf("rst/dbg_r%0d", a), 32'(dbg_data), 32'd0);
    end

    // Basic load/add.
    issue("ldi_r1",  16'hB051, 1'b0, 1'b1, 1'b0, 8'h05, 8'h05);
    issue("ldi_r2",  16'hB072, 1'b0, 1'b1, 1'b0, 8'h07, 8'h07);
    issue("add_r3",  16'h1123, 1'b0, 1'b1, 1'b0, 8'h0C, 8'h0C);
    chk("add_r3/ovf", 32'(ovf_flag), 32'd0);
    chk("add_r3/udf", 32'(udf_flag), 32'd0);

    // Carry out of ADD: 0xF0 + 0xF0 = 0x1E0.
    issue("ldi_r4",  16'hB0F4, 1'b0, 1'b1, 1'b0, 8'h0F, 8'h0F);
    issue("shl_r4",  16'h8444, 1'b0, 1'b1, 1'b0, 8'hF0, 8'hF0);
    issue("add_ovf", 16'h1445, 1'b0, 1'b1, 1'b0, EXP_ADD_OVF, EXP_ADD_OVF);
    chk("add_ovf/ovf", 32'(ovf_flag), 32'd1);
    chk("add_ovf/udf", 32'(udf_flag), 32'd0);

    // Borrow: r0 (0) - 1.
    issue("subi_udf", 16'h7016, 1'b0, 1'b1, 1'b0, EXP_SUBI_UDF, EXP_SUBI_UDF);
    chk("subi_udf/udf", 32'(udf_flag), 32'd1);
    issue("add_r7",  16'h1127, 1'b0, 1'b1, 1'b0, 8'h0C, 8'h0C);
    chk("sticky/udf", 32'(udf_flag), 32'd1);
    chk("sticky/ovf", 32'(ovf_flag), 32'd1);

    // Remaining opcodes: r1=05 r2=07 r3=0C r4=F0.
    issue("sub_r8",  16'h2218, 1'b0, 1'b1, 1'b0, 8'h02, 8'h02);
    issue("and_r9",  16'h3329, 1'b0, 1'b1, 1'b0, 8'h04, 8'h04);
    issue("or_rA",   16'h432A, 1'b0, 1'b1, 1'b0, 8'h0F, 8'h0F);
    issue("xor_rB",  16'h532B, 1'b0, 1'b1, 1'b0, 8'h0B, 8'h0B);
    issue("shr_rC",  16'h943C, 1'b0, 1'b1, 1'b0, 8'h1E, 8'h1E);
    issue("mov_rD",  16'hA30D, 1'b0, 1'b1, 1'b0, 8'h0C, 8'h0C);
    issue("addi_rE", 16'h619E, 1'b0, 1'b1, 1'b0, 8'h0E, 8'h0E);
    // rw == ra: reads 5 before writing 6.
    issue("addi_r1_r1", 16'h6111, 1'b0, 1'b1, 1'b0, 8'h06, 8'h06);

    // NOP: no pulse, no write, still four cycles.
    issue("nop",     16'h0000, 1'b0, 1'b0, 1'b0, 8'h06, 8'h00);

    // Illegal opcode 0xD with instr_valid held while busy.
    issue("illegal", 16'hD123, 1'b1, 1'b0, 1'b1, 8'h06, 8'h0C);
    extra_rv  = 0;
    extra_ill = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (result_valid) extra_rv++;
      if (illegal_op) extra_ill++;
    end
    chk("illegal/no_reaccept_ill", 32'(extra_ill), 32'd0);
    chk("illegal/no_reaccept_rv", 32'(extra_rv), 32'd0);
    chk("illegal/ready_idle", 32'(instr_ready), 32'd1);

    // Reset during EXEC of ADD r1,r2->rF: no write-back.
    @(negedge clk);
    instr       = 16'h112F;
    instr_valid = 1'b1;
    dbg_addr    = 4'hF;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("abort/busy_decode", 32'(instr_ready), 32'd0);
    @(negedge clk);
    chk("abort/busy_exec", 32'(instr_ready), 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort/ready", 32'(instr_ready), 32'd1);
    chk("abort/result_valid", 32'(result_valid), 32'd0);
    chk("abort/result", 32'(result), 32'd0);
    chk("abort/ovf", 32'(ovf_flag), 32'd0);
    chk("abort/udf", 32'(udf_flag), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    extra_rv = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (result_valid) extra_rv++;
    end
    chk("abort/no_wb_pulse", 32'(extra_rv), 32'd0);
    chk("abort/dbg_rF", 32'(dbg_data), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
